// File: rtl/acc_op_seq.sv
// acc_op_seq: buffers a short {ctrl, b} program and replays it into the accumulator, once or looping.
module acc_op_seq #(
    parameter int          DEPTH    = 8,
    parameter int          AW       = 3,
    parameter logic [4:0]  NOP_CTRL = 5'b11111
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [4:0]    wr_ctrl,
    input  logic [3:0]    wr_b,
    input  logic          clr,
    input  logic          start,
    input  logic          loop_en,
    input  logic          stop,
    output logic [4:0]    ctrl,
    output logic [3:0]    b,
    output logic          issue,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic [AW:0]   len
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          loop_q, loop_d;
    logic          full_q, full_d;
    logic [4:0]    ctrl_q, ctrl_d;
    logic [3:0]    b_q, b_d;
    logic          issue_q, issue_d;
    logic          wr_go;
    logic          last;
    logic [8:0]    mem_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
        loop_d   = loop_q;
        ctrl_d   = NOP_CTRL;
        b_d      = '0;
        issue_d  = 1'b0;
        wr_go    = 1'b0;
        last     = {1'b0, rd_ptr_q} == len_q - (AW+1)'(1);
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (clr)
                    len_d = '0;
                else if (wr_en && !full_q) begin
                    wr_go = 1'b1;
                    len_d = len_q + (AW+1)'(1);
                end
                // entry 0 is read from the old contents; an append never touches it when len != 0
                if (start && len_q != '0) begin
                    state_d  = RUN;
                    loop_d   = loop_en;
                    rd_ptr_d = '0;
                    {ctrl_d, b_d} = mem_q[rd_ptr_d];
                    issue_d  = 1'b1;
                end
            end
            RUN: begin
                if (stop || (last && !loop_q))
                    state_d = DONE;
                else begin
                    rd_ptr_d = last ? '0 : rd_ptr_q + AW'(1);
                    {ctrl_d, b_d} = mem_q[rd_ptr_d];
                    issue_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        full_d = len_d == (AW+1)'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            len_q    <= '0;
            rd_ptr_q <= '0;
            loop_q   <= 1'b0;
            full_q   <= 1'b0;
            ctrl_q   <= NOP_CTRL;
            b_q      <= '0;
            issue_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
            loop_q   <= loop_d;
            full_q   <= full_d;
            ctrl_q   <= ctrl_d;
            b_q      <= b_d;
            issue_q  <= issue_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_go)
            mem_q[len_q[AW-1:0]] <= {wr_ctrl, wr_b};
    end

    assign ctrl  = ctrl_q;
    assign b     = b_q;
    assign issue = issue_q;
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign full  = full_q;
    assign len   = len_q;
endmodule

// File: tb/tb_acc_op_seq.sv
// tb_acc_op_seq: random and directed stimulus; a program-queue reference model feeds a per-cycle scoreboard.
module tb_acc_op_seq;
    logic       clk = 1'b0;
    logic       rst_n, wr_en, clr, start, loop_en, stop;
    logic [4:0] wr_ctrl, ctrl;
    logic [3:0] wr_b, b;
    logic       issue, busy, done, full;
    logic [3:0] len;

    typedef struct packed {
        logic [4:0] ctrl;
        logic [3:0] b;
        logic       issue;
        logic       busy;
        logic       done;
        logic       full;
        logic [3:0] len;
    } obs_t;

    obs_t       exp_q[$];
    logic [8:0] prog[$];
    bit         m_run, m_loop;
    int         m_pos;
    int         checks, passed;

    acc_op_seq dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ctrl(wr_ctrl), .wr_b(wr_b),
        .clr(clr), .start(start), .loop_en(loop_en), .stop(stop),
        .ctrl(ctrl), .b(b), .issue(issue), .busy(busy), .done(done),
        .full(full), .len(len)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs and pushes the response the model expects after the next edge.
    task automatic step(input bit r, input bit w, input logic [4:0] wc, input logic [3:0] wb,
                        input bit c, input bit s, input bit l, input bit sp);
        obs_t e;
        int   osz;
        rst_n = r; wr_en = w; wr_ctrl = wc; wr_b = wb; clr = c; start = s; loop_en = l; stop = sp;
        e = '0;
        e.ctrl = 5'b11111;
        if (!r) begin
            prog.delete();
            m_run = 0;
        end else if (m_run) begin
            if (sp || (m_pos == prog.size() - 1 && !m_loop)) begin
                m_run = 0;
                e.done = 1'b1;
            end else
                m_pos = (m_pos + 1) % prog.size();
        end else begin
            osz = prog.size();
            if (c) prog.delete();
            else if (w && prog.size() < 8) prog.push_back({wc, wb});
            if (s && osz != 0) begin
                m_run = 1; m_pos = 0; m_loop = l;
            end
        end
        if (m_run) begin
            {e.ctrl, e.b} = prog[m_pos];
            e.issue = 1'b1;
            e.busy = 1'b1;
        end
        e.len = 4'(prog.size());
        e.full = prog.size() == 8;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input logic [4:0] wc, input logic [3:0] wb);
        step(1, 1, wc, wb, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            obs_t a, e;
            @(posedge clk);
            #1;
            a = '{ctrl, b, issue, busy, done, full, len};
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL cycle_out t=%0t got %h but no expectation queued", $time, a);
            else begin
                e = exp_q.pop_front();
                if (a === e) passed++;
                else $display("FAIL cycle_out t=%0t got ctrl=%b b=%h iss=%b busy=%b done=%b full=%b len=%0d required ctrl=%b b=%h iss=%b busy=%b done=%b full=%b len=%0d",
                              $time, a.ctrl, a.b, a.issue, a.busy, a.done, a.full, a.len,
                              e.ctrl, e.b, e.issue, e.busy, e.done, e.full, e.len);
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        wr(5'b01001, 4'd3);
        wr(5'b01001, 4'd5);
        wr(5'b00110, 4'd1);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle(6);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) wr(5'(i + 3), 4'(i));
        idle(1);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        idle(3);
        wr(5'b10000, 4'hA);
        wr(5'b00001, 4'h5);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        idle(6);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(3);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) wr(5'b11100, 4'(i));
        step(1, 1, 5'b00000, 4'hF, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle(4);
        step(1, 1, 5'b01111, 4'h7, 1, 0, 0, 0);
        wr(5'b00011, 4'h2);
        step(1, 0, 0, 0, 0, 1, 1, 0);
        idle(5);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            bit c, s;
            c = $urandom_range(0, 99) < 3;
            s = !c && $urandom_range(0, 99) < 10;
            step($urandom_range(0, 199) != 0, $urandom_range(0, 99) < 35, 5'($urandom), 4'($urandom),
                 c, s, 1'($urandom), $urandom_range(0, 99) < 6);
        end
        idle(2);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL queue_drain got %0d leftover expectations, required 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
